// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline registers: control-field widths,
// the packed E-stage control bundle and its bubble value.
package pipe_pkg;

    localparam int RESSRC_W  = 2;
    localparam int IMMSRC_W  = 3;
    localparam int ALUCTRL_W = 4;

    // Every control bit carried from decode to execute, valid bit first.
    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic                 alu_src_a;
        logic                 alu_src_b;
        logic                 ld_src;
        logic                 st_src;
        logic                 jal_src;
        logic [RESSRC_W-1:0]  result_src;
        logic [ALUCTRL_W-1:0] alu_control;
        logic [IMMSRC_W-1:0]  imm_src;
    } ctrl_t;

    // Bubble: nothing valid, no side effects, all selects zero.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register. Priority per edge: rst > clr > hold > load.
// Clear and reset both force zero so a bubble never carries stale or X data.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Sync reset, then clear (bubble), then hold when not enabled.
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register with stall, flush and a valid bit.
// Optional stall/flush performance counters under `define PIPE_PERF_EN.
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RESSRC_W   = pipe_pkg::RESSRC_W,
    parameter int IMMSRC_W   = pipe_pkg::IMMSRC_W,
    parameter int ALUCTRL_W  = pipe_pkg::ALUCTRL_W
`ifdef PIPE_PERF_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcAD,
    input  logic                  ALUSrcBD,
    input  logic                  LdSrcD,
    input  logic                  StSrcD,
    input  logic                  JalSrcD,
    input  logic [RESSRC_W-1:0]   ResultSrcD,
    input  logic [ALUCTRL_W-1:0]  ALUControlD,
    input  logic [IMMSRC_W-1:0]   ImmSrcD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic                  LdSrcE,
    output logic                  StSrcE,
    output logic                  JalSrcE,
    output logic [RESSRC_W-1:0]   ResultSrcE,
    output logic [ALUCTRL_W-1:0]  ALUControlE,
    output logic [IMMSRC_W-1:0]   ImmSrcE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [DATA_WIDTH-1:0] PCE,
`ifdef PIPE_PERF_EN
    output logic [CNT_W-1:0]      StallCntE,
    output logic [CNT_W-1:0]      FlushCntE,
`endif
    output logic [DATA_WIDTH-1:0] PCPlus4E
);

    import pipe_pkg::*;

    // The control bundle is a fixed package struct; the width parameters
    // exist for port sizing and must agree with it.
    if (RESSRC_W != pipe_pkg::RESSRC_W || IMMSRC_W != pipe_pkg::IMMSRC_W ||
        ALUCTRL_W != pipe_pkg::ALUCTRL_W) begin : g_bad_ctrl_width
        $error("id_ex_pipe_reg: control widths must match pipe_pkg");
    end

    localparam int DP_W = 5 * DATA_WIDTH + 3 * REG_ADDR_W;

    ctrl_t            w_ctrl_d;
    ctrl_t            w_ctrl_q;
    logic [DP_W-1:0]  w_dp_d;
    logic [DP_W-1:0]  w_dp_q;
    logic             w_load_en;

    // Flush has priority over stall inside the field register.
    assign w_load_en = ~StallE;

    assign w_ctrl_d = '{
        valid:       ValidD,
        reg_write:   RegWriteD,
        mem_write:   MemWriteD,
        jump:        JumpD,
        branch:      BranchD,
        alu_src_a:   ALUSrcAD,
        alu_src_b:   ALUSrcBD,
        ld_src:      LdSrcD,
        st_src:      StSrcD,
        jal_src:     JalSrcD,
        result_src:  ResultSrcD,
        alu_control: ALUControlD,
        imm_src:     ImmSrcD
    };

    assign w_dp_d = {RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};

    pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
        .clk   (clk),
        .rst   (rst),
        .i_clr (FlushE),
        .i_en  (w_load_en),
        .i_d   (w_ctrl_d),
        .o_q   (w_ctrl_q)
    );

    pipe_field_reg #(.W(DP_W)) u_dp_reg (
        .clk   (clk),
        .rst   (rst),
        .i_clr (FlushE),
        .i_en  (w_load_en),
        .i_d   (w_dp_d),
        .o_q   (w_dp_q)
    );

    assign ValidE      = w_ctrl_q.valid;
    assign RegWriteE   = w_ctrl_q.reg_write;
    assign MemWriteE   = w_ctrl_q.mem_write;
    assign JumpE       = w_ctrl_q.jump;
    assign BranchE     = w_ctrl_q.branch;
    assign ALUSrcAE    = w_ctrl_q.alu_src_a;
    assign ALUSrcBE    = w_ctrl_q.alu_src_b;
    assign LdSrcE      = w_ctrl_q.ld_src;
    assign StSrcE      = w_ctrl_q.st_src;
    assign JalSrcE     = w_ctrl_q.jal_src;
    assign ResultSrcE  = w_ctrl_q.result_src;
    assign ALUControlE = w_ctrl_q.alu_control;
    assign ImmSrcE     = w_ctrl_q.imm_src;

    assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = w_dp_q;

`ifdef PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counts of stalled (non-flushed) and flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (FlushE && r_flush_cnt != CNT_MAX)
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            if (StallE && !FlushE && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign StallCntE = r_stall_cnt;
    assign FlushCntE = r_flush_cnt;
`endif

endmodule
